addsub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit add_sub unit between NREQ requesters.
- Latches the winning requester's operands and drives the unit's cs/SUB/A/B/CIN.
- Tracks the unit's rdy handshake, captures SUM/COUT, and returns the result with a one-cycle done pulse to the owner.
- Sits between the microprocessor's execution sources (ALU path, address calc, etc.) and the single shared add_sub instance.

---
 rtl/addsub_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter/sequencer sharing one 16-bit add_sub unit
// between NREQ requesters. It latches the winner's operands, drives the unit's
// cs/SUB/A/B/CIN, follows the unit's rdy handshake and returns SUM/COUT with a
// one-cycle done pulse to the owner.
// Optional feature: define ARB_TIMEOUT_EN to enable the WAIT_LO/WAIT_HI watchdog.
module addsub_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    input  logic [NREQ-1:0]   cin_in,
    input  logic [NREQ-1:0]   sub_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              cout_out,
    output logic              busy,
    output logic              err,
    output logic              au_cs,
    output logic              au_sub,
    output logic [W-1:0]      au_a,
    output logic [W-1:0]      au_b,
    output logic              au_cin,
    input  logic [W-1:0]      au_sum,
    input  logic              au_cout,
    input  logic              au_rdy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StIssue,
        StWaitLo,
        StWaitHi,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic [W-1:0]      au_a_q, au_a_d;
    logic [W-1:0]      au_b_q, au_b_d;
    logic              au_sub_q, au_sub_d;
    logic              au_cin_q, au_cin_d;
    logic              rdy_seen_q, rdy_seen_d;
    logic              err_q, err_d;
    logic              timeout_hit;

    // Round-robin pick
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_gnt;
    logic [W-1:0]      pick_a;
    logic [W-1:0]      pick_b;
    logic              pick_cin;
    logic              pick_sub;
    int                idx;

`ifdef ARB_TIMEOUT_EN
    logic [3:0]        cnt_q, cnt_d;

    // Watchdog: cleared on entry to WAIT_LO, saturating count through both waits
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIssue) begin
            cnt_d = 4'd0;
        end else if ((state_q == StWaitLo || state_q == StWaitHi) && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q >= 4'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT only matters with the watchdog; keep a harmless reference to it.
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    // Search upward from rr+1 (mod NREQ) for the first requesting slot
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_gnt   = '0;
        pick_a     = '0;
        pick_b     = '0;
        pick_cin   = 1'b0;
        pick_sub   = 1'b0;
        idx        = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (int'(rr_q) + k) % int'(NREQ);
            if (!pick_found && req[idx]) begin
                pick_found    = 1'b1;
                pick_idx      = IW'(idx);
                pick_gnt[idx] = 1'b1;
                pick_a        = a_in[idx*W +: W];
                pick_b        = b_in[idx*W +: W];
                pick_cin      = cin_in[idx];
                pick_sub      = sub_in[idx];
            end
        end
    end

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        result_d   = result_q;
        cout_d     = cout_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_sub_d   = au_sub_q;
        au_cin_d   = au_cin_q;
        rdy_seen_d = rdy_seen_q;
        err_d      = err_q;
        unique case (state_q)
            // The unit has no reset: two consecutive rdy samples prove it is idle.
            StSync: begin
                rdy_seen_d = au_rdy;
                if (au_rdy && rdy_seen_q) begin
                    state_d    = StIdle;
                    rdy_seen_d = 1'b0;
                end
            end
            StIdle: begin
                if (pick_found) begin
                    gnt_d    = pick_gnt;
                    owner_d  = pick_idx;
                    au_a_d   = pick_a;
                    au_b_d   = pick_b;
                    au_cin_d = pick_cin;
                    au_sub_d = pick_sub;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!au_rdy) begin
                    state_d = StWaitHi;
                end else if (timeout_hit) begin
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StWaitHi: begin
                if (au_rdy) begin
                    result_d = au_sum;
                    cout_d   = au_cout;
                    state_d  = StDone;
                end else if (timeout_hit) begin
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                rr_d       = owner_q;
                gnt_d      = '0;
                err_d      = 1'b0;
                rdy_seen_d = 1'b0;
                // After a timeout the unit state is unknown, so resynchronise.
                state_d    = err_q ? StSync : StIdle;
            end
            default: begin
                state_d = StSync;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSync;
            gnt_q      <= '0;
            rr_q       <= IW'(NREQ - 1);
            owner_q    <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            au_a_q     <= '0;
            au_b_q     <= '0;
            au_sub_q   <= 1'b0;
            au_cin_q   <= 1'b0;
            rdy_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            au_a_q     <= au_a_d;
            au_b_q     <= au_b_d;
            au_sub_q   <= au_sub_d;
            au_cin_q   <= au_cin_d;
            rdy_seen_q <= rdy_seen_d;
            err_q      <= err_d;
        end
    end

    // Outputs decoded from state; operands come straight from their registers
    always_comb begin
        gnt      = gnt_q;
        done     = (state_q == StDone) ? gnt_q : '0;
        result   = result_q;
        cout_out = cout_q;
        busy     = (state_q != StIdle);
        au_cs    = (state_q == StIssue);
        au_a     = au_a_q;
        au_b     = au_b_q;
        au_sub   = au_sub_q;
        au_cin   = au_cin_q;
`ifdef ARB_TIMEOUT_EN
        err      = err_q && (state_q == StDone);
`else
        err      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter with a behavioural add_sub unit.
module tb_addsub_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req;
    logic [W-1:0]      a_arr [NREQ];
    logic [W-1:0]      b_arr [NREQ];
    logic [NREQ*W-1:0] a_in, b_in;
    logic [NREQ-1:0]   cin_in, sub_in;
    logic [NREQ-1:0]   gnt, done;
    logic [W-1:0]      result;
    logic              cout_out, busy, err;
    logic              au_cs, au_sub, au_cin;
    logic [W-1:0]      au_a, au_b, au_sum;
    logic              au_cout, au_rdy;

    assign a_in = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign b_in = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    addsub_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .cin_in(cin_in), .sub_in(sub_in), .gnt(gnt), .done(done), .result(result),
        .cout_out(cout_out), .busy(busy), .err(err), .au_cs(au_cs), .au_sub(au_sub),
        .au_a(au_a), .au_b(au_b), .au_cin(au_cin), .au_sum(au_sum), .au_cout(au_cout),
        .au_rdy(au_rdy)
    );

    // Unit model: rdy drops the cycle after cs, returns one cycle later.
    logic        u_rdy = 1'b1;
    logic        stuck = 1'b0;
    logic [16:0] u_res;
    always_comb begin
        u_res = au_sub ? ({1'b0, au_a} + {1'b0, ~au_b} + 17'd1)
                       : ({1'b0, au_a} + {1'b0, au_b} + {16'd0, au_cin});
    end
    assign au_sum  = u_res[15:0];
    assign au_cout = u_res[16];
    assign au_rdy  = u_rdy;
    always @(posedge clk) u_rdy <= stuck ? 1'b0 : !au_cs;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n counts sampling edges since the grant edge (caller is already 1 past it)
    task automatic wait_done(input int bound, output int n);
        n = 1;
        while (done == '0 && n < bound) begin
            tick();
            n++;
        end
        check_eq("done_seen", 32'(done != '0), 1);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_cout", cout_out, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_au_cs", au_cs, 0);
        check_eq("rst_au_a", au_a, 0);
        check_eq("rst_au_b", au_b, 0);
        check_eq("rst_au_sub", au_sub, 0);
        check_eq("rst_au_cin", au_cin, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();
        check_eq("sync_busy_1", busy, 1);
        tick();
        check_eq("sync_busy_0", busy, 0);
        check_eq("sync_gnt", gnt, 0);
    endtask

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] exp_res, input logic exp_cout);
        int n;
        a_arr[i] = a;
        b_arr[i] = b;
        cin_in[i] = cin;
        sub_in[i] = sub;
        req[i] = 1'b1;
        tick();
        check_eq("op_gnt", gnt, 32'(1) << i);
        check_eq("op_cs", au_cs, 1);
        check_eq("op_au_a", au_a, a);
        check_eq("op_au_b", au_b, b);
        check_eq("op_au_sub", au_sub, sub);
        wait_done(20, n);
        check_eq("op_latency", n, 4);
        check_eq("op_done", done, 32'(1) << i);
        check_eq("op_result", result, exp_res);
        check_eq("op_cout", cout_out, exp_cout);
        check_eq("op_err", err, 0);
        req[i] = 1'b0;
        tick();
        check_eq("op_done_clr", done, 0);
        check_eq("op_gnt_clr", gnt, 0);
        check_eq("op_idle", busy, 0);
    endtask

    logic [15:0] rr_exp [4];

    initial begin
        int n, cyc, last, w;
        req = '0;
        cin_in = '0;
        sub_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        tick();
        do_reset();

        // Add and subtract cases
        run_op(0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0);
        run_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op(2, 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);

        // Reset during WAIT_HI, then resynchronise with rdy held low for a while
        a_arr[1] = 16'h1234;
        b_arr[1] = 16'h1111;
        cin_in[1] = 1'b0;
        sub_in[1] = 1'b0;
        req[1] = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        stuck = 1'b1;
        #1;
        check_reset_vals();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("resync_stuck_busy", busy, 1);
        check_eq("resync_stuck_gnt", gnt, 0);
        stuck = 1'b0;
        tick();
        check_eq("resync_busy_a", busy, 1);
        tick();
        check_eq("resync_busy_b", busy, 1);
        tick();
        check_eq("resync_idle", busy, 0);
        check_eq("resync_gnt0", gnt, 0);
        tick();
        check_eq("resync_gnt", gnt, 32'h2);
        wait_done(20, n);
        check_eq("resync_latency", n, 4);
        check_eq("resync_result", result, 16'h2345);
        req[1] = 1'b0;
        tick();

        // Round robin with all requesters holding req
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'(16'h1111 * (i + 1));
            b_arr[i] = 16'h0001;
            cin_in[i] = 1'b0;
            sub_in[i] = 1'b0;
        end
        rr_exp[0] = 16'h1112;
        rr_exp[1] = 16'h2223;
        rr_exp[2] = 16'h3334;
        rr_exp[3] = 16'h4445;
        req = '1;
        cyc = 0;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            do begin
                tick();
                cyc++;
                w++;
                check_eq("rr_gnt_onehot0", 32'($onehot0(gnt)), 1);
            end while (done == '0 && w < 10);
            check_eq("rr_done", done, 32'(1) << (k % 4));
            check_eq("rr_gnt", gnt, 32'(1) << (k % 4));
            check_eq("rr_result", result, rr_exp[k % 4]);
            if (k > 0) check_eq("rr_gap_le6", 32'((cyc - last) <= 6), 1);
            last = cyc;
        end
        req = '0;
        tick();
        check_eq("rr_idle", busy, 0);

`ifdef ARB_TIMEOUT_EN
        // Unit never returns rdy: watchdog forces DONE with err, then SYNC
        stuck = 1'b1;
        a_arr[2] = 16'h0F0F;
        b_arr[2] = 16'h0101;
        req[2] = 1'b1;
        tick();
        wait_done(40, n);
        check_eq("to_latency", n, TIMEOUT + 2);
        check_eq("to_done", done, 32'h4);
        check_eq("to_err", err, 1);
        check_eq("to_result", result, 0);
        check_eq("to_cout", cout_out, 0);
        req[2] = 1'b0;
        tick();
        check_eq("to_sync_busy", busy, 1);
        check_eq("to_sync_gnt", gnt, 0);
        check_eq("to_err_clr", err, 0);
        stuck = 1'b0;
        tick();
        tick();
        tick();
        check_eq("to_resync_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
